// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register behind the 64-bit ALU: MEM-side payload, architectural
// NZCV register, and same-cycle flag bypass feeding B.cond evaluation in EX.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      ex_negative,
  input  logic                      ex_zero,
  input  logic                      ex_overflow,
  input  logic                      ex_carry_out,
  input  logic                      ex_set_flags,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [3:0]                ex_cond,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [3:0]                flags_nzcv,
  output logic                      cond_true
);

  logic [3:0] alu_nzcv;
  logic [3:0] bflags;
  logic       n, z, c, v;

  assign alu_nzcv = {ex_negative, ex_zero, ex_carry_out, ex_overflow};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
      flags_nzcv     <= '0;
    end else if (flush) begin
      // Bubble only: payload and flags keep their values.
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_result     <= ex_result;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_reg_write & ex_valid;
      mem_mem_read   <= ex_mem_read  & ex_valid;
      mem_mem_write  <= ex_mem_write & ex_valid;
      mem_store_data <= ex_store_data;
      if (ex_valid && ex_set_flags)
        flags_nzcv <= alu_nzcv;
    end
  end

  // Bypass deliberately ignores stall so a stalled B.cond sees its own flags.
  assign bflags = (ex_valid && ex_set_flags && !flush) ? alu_nzcv : flags_nzcv;
  assign {n, z, c, v} = bflags;

  always_comb begin
    cond_true = 1'b0;
    unique case (ex_cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = !z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = !c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = !n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = !v;
      4'b1000: cond_true = c && !z;
      4'b1001: cond_true = !(c && !z);
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = !z && (n == v);
      4'b1101: cond_true = !(!z && (n == v));
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a cycle-by-cycle vector table plus
// hand-written sequences for reset, stall/flush priority and flag corner cases.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid;
  logic [63:0] ex_result;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out, ex_set_flags;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [63:0] ex_store_data;
  logic [3:0]  ex_cond;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [63:0] mem_store_data;
  logic [3:0]  flags_nzcv;
  logic        cond_true;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
    .ex_set_flags(ex_set_flags), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .ex_cond(ex_cond),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data),
    .flags_nzcv(flags_nzcv), .cond_true(cond_true)
  );

  typedef struct {
    logic        st, fl, v, sf;
    logic [3:0]  alu;            // {N,Z,C,V}
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [63:0] sd;
    logic [3:0]  cond;
    logic        e_ct;           // cond_true before the edge
    logic        e_v;
    logic [63:0] e_res;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw;
    logic [63:0] e_sd;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    logic st, logic fl, logic v, logic sf, logic [3:0] alu, logic [63:0] res,
    logic [4:0] rd, logic rw, logic mr, logic mw, logic [63:0] sd, logic [3:0] cond,
    logic e_ct, logic e_v, logic [63:0] e_res, logic [4:0] e_rd,
    logic e_rw, logic e_mr, logic e_mw, logic [63:0] e_sd, logic [3:0] e_flags);
    vec_t t;
    t.st = st; t.fl = fl; t.v = v; t.sf = sf; t.alu = alu; t.res = res;
    t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw; t.sd = sd; t.cond = cond;
    t.e_ct = e_ct; t.e_v = e_v; t.e_res = e_res; t.e_rd = e_rd;
    t.e_rw = e_rw; t.e_mr = e_mr; t.e_mw = e_mw; t.e_sd = e_sd; t.e_flags = e_flags;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic sf,
                       input logic [3:0] alu, input logic [63:0] res, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [63:0] sd, input logic [3:0] cond);
    stall = st; flush = fl; ex_valid = v; ex_set_flags = sf;
    {ex_negative, ex_zero, ex_carry_out, ex_overflow} = alu;
    ex_result = res; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_store_data = sd; ex_cond = cond;
  endtask

  task automatic chk_mem(input string tag, input logic e_v, input logic [63:0] e_res,
                         input logic [4:0] e_rd, input logic e_rw, input logic e_mr,
                         input logic e_mw, input logic [63:0] e_sd, input logic [3:0] e_fl);
    chk({tag, ".mem_valid"},      64'(mem_valid),      64'(e_v));
    chk({tag, ".mem_result"},     mem_result,          e_res);
    chk({tag, ".mem_rd"},         64'(mem_rd),         64'(e_rd));
    chk({tag, ".mem_reg_write"},  64'(mem_reg_write),  64'(e_rw));
    chk({tag, ".mem_mem_read"},   64'(mem_mem_read),   64'(e_mr));
    chk({tag, ".mem_mem_write"},  64'(mem_mem_write),  64'(e_mw));
    chk({tag, ".mem_store_data"}, mem_store_data,      e_sd);
    chk({tag, ".flags_nzcv"},     64'(flags_nzcv),     64'(e_fl));
  endtask

  initial begin
    //   st fl v sf alu      res                    rd  rw mr mw sd      cond     ct | v res                   rd  rw mr mw sd     flags
    add(0, 0, 1, 0, 4'b0000, 64'h5,                 3,  1, 0, 0, 64'h0,  4'b0000, 0,  1, 64'h5,                3,  1, 0, 0, 64'h0, 4'b0000); // pass-through, EQ
    add(0, 0, 0, 0, 4'b0000, 64'h7,                 4,  1, 1, 1, 64'h9,  4'b0001, 1,  0, 64'h7,                4,  0, 0, 0, 64'h9, 4'b0000); // invalid gates ctrl, NE
    add(0, 0, 1, 1, 4'b0110, 64'h0,                 1,  1, 0, 0, 64'h0,  4'b0000, 1,  1, 64'h0,                1,  1, 0, 0, 64'h0, 4'b0110); // SUBS 5-5 + B.EQ
    add(0, 0, 1, 0, 4'b0000, 64'h1000,              2,  0, 0, 1, 64'hAB, 4'b0010, 1,  1, 64'h1000,             2,  0, 0, 1, 64'hAB,4'b0110); // store, CS
    add(0, 0, 1, 1, 4'b1001, 64'h8000000000000000,  5,  1, 0, 0, 64'h0,  4'b1011, 0,  1, 64'h8000000000000000, 5,  1, 0, 0, 64'h0, 4'b1001); // ADDS N,V, LT
    add(0, 0, 1, 0, 4'b1111, 64'h20,                6,  1, 1, 0, 64'h0,  4'b1010, 1,  1, 64'h20,               6,  1, 1, 0, 64'h0, 4'b1001); // load, sf=0, GE
    add(0, 1, 1, 1, 4'b0100, 64'h55,                7,  1, 1, 1, 64'h66, 4'b0000, 0,  0, 64'h20,               6,  0, 0, 0, 64'h0, 4'b1001); // flush
    add(1, 0, 1, 1, 4'b0100, 64'h77,                8,  1, 0, 0, 64'h88, 4'b0000, 1,  0, 64'h20,               6,  0, 0, 0, 64'h0, 4'b1001); // stall, bypass
    add(0, 0, 1, 1, 4'b0100, 64'h77,                8,  1, 0, 0, 64'h88, 4'b0000, 1,  1, 64'h77,               8,  1, 0, 0, 64'h88,4'b0100); // release
    add(0, 0, 0, 1, 4'b0010, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b1000, 0,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0100); // HI, no bypass
    add(0, 0, 1, 1, 4'b0010, 64'h1,                 9,  1, 0, 0, 64'h2,  4'b1001, 0,  1, 64'h1,                9,  1, 0, 0, 64'h2, 4'b0010); // LS via bypass
    add(0, 0, 1, 0, 4'b0000, 64'h3,                 10, 0, 0, 0, 64'h4,  4'b1100, 1,  1, 64'h3,                10, 0, 0, 0, 64'h4, 4'b0010); // GT
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b1101, 0,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0010); // LE
    add(0, 0, 1, 1, 4'b0001, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b0110, 1,  1, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // VS via bypass
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b0111, 0,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // VC
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b0101, 1,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // PL
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b0100, 0,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // MI
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b0011, 1,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // CC
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b1110, 1,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // AL
    add(0, 0, 0, 0, 4'b0000, 64'h0,                 0,  0, 0, 0, 64'h0,  4'b1111, 1,  0, 64'h0,                0,  0, 0, 0, 64'h0, 4'b0001); // NV=always

    drive(0, 0, 0, 0, 4'b0000, 64'h0, 0, 0, 0, 0, 64'h0, 4'b0000);
    reset = 1'b0;
    #2;
    chk_mem("reset", 0, 64'h0, 0, 0, 0, 0, 64'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].sf, vecs[i].alu, vecs[i].res,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].sd, vecs[i].cond);
      #1 chk({tag, ".cond_true"}, 64'(cond_true), 64'(vecs[i].e_ct));
      @(posedge clk);
      #1 chk_mem(tag, vecs[i].e_v, vecs[i].e_res, vecs[i].e_rd, vecs[i].e_rw,
                 vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_sd, vecs[i].e_flags);
    end

    // Flush beats stall; flags hold and MI reads the old N.
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b0001, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1110);
    @(posedge clk); #1;
    @(negedge clk);
    drive(1, 1, 1, 1, 4'b1000, 64'hF0, 1, 1, 1, 1, 64'hF1, 4'b0100);
    #1 chk("flushpri.cond_MI", 64'(cond_true), 64'(1'b0));
    @(posedge clk);
    #1 chk_mem("flushpri", 0, 64'h0, 0, 0, 0, 0, 64'h0, 4'b0001);

    // Three-cycle stall with changing EX inputs, then capture on release.
    @(negedge clk);
    drive(0, 0, 1, 0, 4'b0000, 64'h11, 1, 1, 0, 0, 64'h12, 4'b1110);
    @(posedge clk); #1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 0, 1, 1, 4'b1111, 64'h100 + 64'(k), 5'(20 + k), 1, 1, 1, 64'h300 + 64'(k), 4'b1110);
      @(posedge clk);
      #1 chk_mem($sformatf("stall%0d", k), 1, 64'h11, 1, 1, 0, 0, 64'h12, 4'b0001);
    end
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b1111, 64'h200, 12, 1, 0, 1, 64'h201, 4'b1110);
    @(posedge clk);
    #1 chk_mem("stall_release", 1, 64'h200, 12, 1, 0, 1, 64'h201, 4'b1111);

    // Signed conditions on stored flags N=1 Z=0 C=0 V=1, no bypass.
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b1001, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1110);
    @(posedge clk); #1;
    @(negedge clk);
    drive(0, 0, 0, 1, 4'b0110, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1010);
    #1 chk("signed.GE", 64'(cond_true), 64'(1'b1));
    ex_cond = 4'b1011; #1 chk("signed.LT", 64'(cond_true), 64'(1'b0));
    ex_cond = 4'b1100; #1 chk("signed.GT", 64'(cond_true), 64'(1'b1));
    ex_cond = 4'b1101; #1 chk("signed.LE", 64'(cond_true), 64'(1'b0));
    ex_cond = 4'b1000; #1 chk("signed.HI", 64'(cond_true), 64'(1'b0));
    ex_cond = 4'b1110; #1 chk("signed.AL", 64'(cond_true), 64'(1'b1));

    // Back-to-back flag setters: each edge takes its own update.
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b0100, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1110);
    @(posedge clk);
    #1 chk("b2b.first", 64'(flags_nzcv), 64'(4'b0100));
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b1000, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1110);
    @(posedge clk);
    #1 chk("b2b.second", 64'(flags_nzcv), 64'(4'b1000));

    // Asynchronous reset between edges.
    @(negedge clk);
    drive(0, 0, 1, 1, 4'b1010, 64'hDEADBEEF, 7, 1, 1, 0, 64'h5A, 4'b1110);
    @(posedge clk);
    #1 chk("midrun.pre_result", mem_result, 64'hDEADBEEF);
    chk("midrun.pre_flags", 64'(flags_nzcv), 64'(4'b1010));
    #1 reset = 1'b0;
    #1 chk_mem("midrun_reset", 0, 64'h0, 0, 0, 0, 0, 64'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 4'b0000, 64'h0, 0, 0, 0, 0, 64'h0, 4'b1110);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
